// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and the redirect-target helper
// for the fetch queue unit.
package fetch_pkg;

    localparam int XLEN_P = 32;

    localparam logic [XLEN_P-1:0] PC_INC = 32'd4;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN_P-1:0] instr;
        logic [XLEN_P-1:0] pc;
    } fetch_entry_t;

    // JALR clears bit 0 of its sum; JAL and branches use pc + imm.
    function automatic logic [XLEN_P-1:0] redirect_target(
        input logic              jalr,
        input logic [XLEN_P-1:0] ex_pc,
        input logic [XLEN_P-1:0] r1,
        input logic [XLEN_P-1:0] imm
    );
        logic [XLEN_P-1:0] sum;
        sum = jalr ? (r1 + imm) : (ex_pc + imm);
        return jalr ? {sum[XLEN_P-1:1], 1'b0} : sum;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; pop on empty is ignored.
// Ports: clk_i, rst_i, flush_i, push_i/wdata_i, pop_i/rdata_o, count_o, empty_o, full_o.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= nxt(wptr_q);
            if (do_pop)  rptr_q <= nxt(rptr_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) mem_q[wptr_q] <= wdata_i;
    end

    a_no_overflow : assert property (
        @(posedge clk_i) disable iff (rst_i || flush_i)
        !(push_i && full_o && !pop_i)
    );

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: sequential fetch with prefetch queue, in-order imem
// req/gnt/rvalid, redirect flush and misalign halt.
// Ports: clk_i, PCrst_i, BE_i/UJE_i/JALRE_i, ex_pc_i, R1_i, immed_i,
// imem_req_o/addr_o/gnt_i/rvalid_i/rdata_i, instr_valid_o/ready_i/instr_o/pc_o, misalign_o.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = XLEN_P,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk_i,
    input  logic            PCrst_i,
    input  logic            BE_i,
    input  logic            UJE_i,
    input  logic            JALRE_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] R1_i,
    input  logic [XLEN-1:0] immed_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            misalign_o
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int QW = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   disc_q, disc_d;
    logic            mis_q, mis_d;

    logic            redirect;
    logic            aligned;
    logic            fire;
    logic            keep;
    logic [XLEN-1:0] target;

    fetch_entry_t    pf_wdata;
    fetch_entry_t    pf_rdata;
    logic [QW-1:0]   pf_count;
    logic            pf_empty;
    logic            pf_full;

    logic [XLEN-1:0] pend_pc;
    logic [OW-1:0]   outst;
    logic            pend_empty;
    logic            pend_full;

    assign redirect = BE_i | UJE_i | JALRE_i;
    assign target   = redirect_target(JALRE_i, ex_pc_i, R1_i, immed_i);
    assign aligned  = (target[1:0] == 2'b00);

    assign imem_req_o = !PCrst_i && (state_q == RUN) && !redirect
                     && (int'(pf_count) + int'(outst) < DEPTH)
                     && !pend_full;
    assign imem_addr_o = pc_q;
    assign fire        = imem_req_o && imem_gnt_i;

    // Responses owed to a flushed stream are dropped until disc_q drains.
    assign keep     = imem_rvalid_i && (disc_q == '0) && !redirect;
    assign pf_wdata = '{instr: imem_rdata_i, pc: pend_pc};

    // Outstanding count is the occupancy of the pending-PC tracker.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pend (
        .clk_i   (clk_i),
        .rst_i   (PCrst_i),
        .flush_i (1'b0),
        .push_i  (fire),
        .wdata_i (pc_q),
        .pop_i   (imem_rvalid_i),
        .rdata_o (pend_pc),
        .count_o (outst),
        .empty_o (pend_empty),
        .full_o  (pend_full)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_pf (
        .clk_i   (clk_i),
        .rst_i   (PCrst_i),
        .flush_i (redirect),
        .push_i  (keep),
        .wdata_i (pf_wdata),
        .pop_i   (instr_ready_i),
        .rdata_o (pf_rdata),
        .count_o (pf_count),
        .empty_o (pf_empty),
        .full_o  (pf_full)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        disc_d  = disc_q;
        mis_d   = 1'b0;
        if (redirect) begin
            // No grant is possible this cycle, so what remains in
            // flight after this response is exactly what must be dropped.
            disc_d = outst - OW'(imem_rvalid_i);
            if (aligned) begin
                pc_d    = target;
                state_d = RUN;
            end else begin
                mis_d   = 1'b1;
                state_d = HALT;
            end
        end else begin
            if (fire) pc_d = pc_q + PC_INC;
            if (imem_rvalid_i && disc_q != '0) disc_d = disc_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (PCrst_i) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            disc_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            disc_q  <= disc_d;
            mis_q   <= mis_d;
        end
    end

    assign instr_valid_o = !pf_empty;
    assign instr_o       = pf_empty ? '0 : pf_rdata.instr;
    assign instr_pc_o    = pf_empty ? '0 : pf_rdata.pc;
    assign misalign_o    = mis_q;

    a_full_no_req : assert property (
        @(posedge clk_i) disable iff (PCrst_i) pf_full |-> !imem_req_o
    );

    a_rsp_has_req : assert property (
        @(posedge clk_i) disable iff (PCrst_i) imem_rvalid_i |-> !pend_empty
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed bench with an in-order latency-1 memory
// responder and a delivered-PC log.
module tb_fetch_queue_unit;

    logic        clk_i = 1'b0;
    logic        PCrst_i;
    logic        BE_i, UJE_i, JALRE_i;
    logic [31:0] ex_pc_i, R1_i, immed_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o, instr_ready_i;
    logic [31:0] instr_o, instr_pc_o;
    logic        misalign_o;

    int          checks = 0;
    int          errors = 0;
    int          fires  = 0;
    logic        rsp_en;
    logic [31:0] rsp_q [$];
    logic [31:0] dlv_q [$];

    always #5 clk_i = ~clk_i;

    fetch_queue_unit dut (
        .clk_i         (clk_i),
        .PCrst_i       (PCrst_i),
        .BE_i          (BE_i),
        .UJE_i         (UJE_i),
        .JALRE_i       (JALRE_i),
        .ex_pc_i       (ex_pc_i),
        .R1_i          (R1_i),
        .immed_i       (immed_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .misalign_o    (misalign_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dlv_at(input int i);
        return (dlv_q.size() > i) ? dlv_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        logic        f;
        logic [31:0] a;
        #1;
        f = imem_req_o && imem_gnt_i;
        a = imem_addr_o;
        if (f) fires++;
        if (instr_valid_o && instr_ready_i) begin
            dlv_q.push_back(instr_pc_o);
            chk("word", instr_o, mem_word(instr_pc_o));
        end
        @(posedge clk_i);
        #1;
        if (PCrst_i) begin
            rsp_q.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end else begin
            if (f) rsp_q.push_back(a);
            if (rsp_en && rsp_q.size() != 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(rsp_q.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
            end
        end
    endtask

    task automatic do_reset();
        PCrst_i = 1'b1;
        tick();
        PCrst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        PCrst_i = 1'b1;
        BE_i = 0; UJE_i = 0; JALRE_i = 0;
        ex_pc_i = '0; R1_i = '0; immed_i = '0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
        instr_ready_i = 0; rsp_en = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_mis", misalign_o, 0);
        chk("rst_instr", instr_o, 0);

        PCrst_i = 0; imem_gnt_i = 1; instr_ready_i = 1;
        tick(); #1;
        chk("seq_fill", instr_valid_o, 0);
        tick(); #1;
        chk("seq_v0", instr_valid_o, 1);
        chk("seq_pc0", instr_pc_o, 0);
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            chk("seq_v", instr_valid_o, 1);
            chk("seq_pc", instr_pc_o, 32'(4 * i));
        end

        do_reset();
        instr_ready_i = 0;
        repeat (10) tick();
        #1;
        chk("bp_req", imem_req_o, 0);
        chk("bp_valid", instr_valid_o, 1);
        chk("bp_head", instr_pc_o, 0);
        instr_ready_i = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("bp_pc", instr_pc_o, 32'(4 * i));
            if (i == 0) chk("bp_req_r0", imem_req_o, 0);
            tick();
        end

        do_reset();
        instr_ready_i = 1; rsp_en = 0;
        tick();
        tick();
        #1;
        chk("br_hold_req", imem_req_o, 0);
        BE_i = 1; ex_pc_i = 32'h8; immed_i = 32'h10; rsp_en = 1;
        tick();
        BE_i = 0;
        dlv_q.delete();
        #1;
        chk("br_valid", instr_valid_o, 0);
        chk("br_addr", imem_addr_o, 32'h18);
        repeat (6) tick();
        chk("br_first", dlv_at(0), 32'h18);
        chk("br_second", dlv_at(1), 32'h1C);

        JALRE_i = 1; R1_i = 32'h101; immed_i = 32'h3;
        tick();
        JALRE_i = 0;
        dlv_q.delete();
        #1;
        chk("jalr_addr", imem_addr_o, 32'h104);
        chk("jalr_mis", misalign_o, 0);
        chk("jalr_valid", instr_valid_o, 0);
        repeat (6) tick();
        chk("jalr_first", dlv_at(0), 32'h104);

        JALRE_i = 1; R1_i = 32'h102; immed_i = 32'h0;
        tick();
        JALRE_i = 0;
        dlv_q.delete();
        fires = 0;
        #1;
        chk("mis_pulse", misalign_o, 1);
        chk("mis_req", imem_req_o, 0);
        chk("mis_valid", instr_valid_o, 0);
        tick(); #1;
        chk("mis_once", misalign_o, 0);
        repeat (5) tick();
        #1;
        chk("halt_fires", fires, 0);
        chk("halt_dlv", dlv_q.size(), 0);
        chk("halt_valid", instr_valid_o, 0);
        UJE_i = 1; ex_pc_i = 32'h200; immed_i = 32'h20;
        #1;
        chk("jal_redir_req", imem_req_o, 0);
        tick();
        UJE_i = 0;
        #1;
        chk("jal_req", imem_req_o, 1);
        chk("jal_addr", imem_addr_o, 32'h220);
        repeat (6) tick();

        JALRE_i = 1; UJE_i = 1; BE_i = 1;
        R1_i = 32'h300; immed_i = 32'h10; ex_pc_i = 32'h400;
        #1;
        chk("col_head", instr_valid_o, 1);
        tick();
        JALRE_i = 0; UJE_i = 0; BE_i = 0;
        dlv_q.delete();
        #1;
        chk("prio_addr", imem_addr_o, 32'h310);
        chk("col_valid", instr_valid_o, 0);
        repeat (6) tick();
        chk("col_first", dlv_at(0), 32'h310);
        chk("col_second", dlv_at(1), 32'h314);

        do_reset();
        instr_ready_i = 0;
        repeat (3) tick();
        #1;
        chk("mid_valid", instr_valid_o, 1);
        PCrst_i = 1;
        tick();
        #1;
        chk("mid_rst_valid", instr_valid_o, 0);
        chk("mid_rst_addr", imem_addr_o, 0);
        chk("mid_rst_req", imem_req_o, 0);
        PCrst_i = 0; instr_ready_i = 1;
        dlv_q.delete();
        tick();
        tick(); #1;
        chk("mid_pc0", instr_pc_o, 0);
        tick(); #1;
        chk("mid_pc1", instr_pc_o, 32'h4);
        tick();
        chk("mid_first", dlv_at(0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
